// File: rtl/md_sequencer.sv
// md_sequencer
//   Multi-cycle multiply/divide sequencer that owns the architectural HI/LO
//   pair for the EX stage. MULT/MULTU run a radix-2 shift-add multiply and
//   DIV/DIVU run a restoring divide; both take 32 iteration cycles plus one
//   fix-up cycle that applies result signs and writes HI/LO. MTHI/MTLO write
//   HI/LO directly from IDLE.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    EX presents a valid MD command this cycle
//   func     0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   a, b     forwarded rs / rt operands
//   hilo_rd  instruction in EX reads HI or LO
//   flush    abort any in-flight operation, ignore a same-cycle start
//   stall    combinational pipeline freeze request
//   busy     registered, iterative operation in flight
//   done     registered one-cycle pulse after MULT/DIV writes HI/LO
//   hi, lo   architectural HI/LO registers
module md_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  func,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_rd,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    F_NOP   = 3'd0,
    F_MULT  = 3'd1,
    F_MULTU = 3'd2,
    F_DIV   = 3'd3,
    F_DIVU  = 3'd4,
    F_MTHI  = 3'd5,
    F_MTLO  = 3'd6,
    F_RSVD  = 3'd7
  } func_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [63:0] acc;     // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [31:0] opnd;    // multiplicand (MUL) or divisor (DIV), already made unsigned
  logic        q_neg;   // negate product / quotient in FIX
  logic        r_neg;   // negate remainder in FIX
  logic        is_div;

  // Operand conditioning for the signed variants.
  logic        sgn;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  assign sgn   = (func == F_MULT) || (func == F_DIV);
  assign abs_a = (sgn && a[31]) ? -a : a;
  assign abs_b = (sgn && b[31]) ? -b : b;

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole 65-bit value right.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};

  // One restoring step. The shifted remainder needs 33 bits, but whenever the
  // subtraction is kept its result is below the divisor, so 32 bits suffice.
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  assign div_shift = {acc[63:32], acc[31]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_diff  = div_shift[31:0] - opnd;

  // Sign fix-up applied in FIX.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  assign prod_fix = q_neg ? -acc : acc;
  assign quo_fix  = q_neg ? -acc[31:0] : acc[31:0];
  assign rem_fix  = r_neg ? -acc[63:32] : acc[63:32];

  assign stall = (state != IDLE) && (start || hilo_rd) && !flush;

  // NOTE: every register below is updated with <= so all of them sample the
  // pre-edge values; a blocking = here would let later statements see
  // already-updated state and silently change the datapath behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      is_div <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        // Abort: nothing reaches HI/LO and a same-cycle start is dropped.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              case (func)
                F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                  is_div <= (func == F_DIV) || (func == F_DIVU);
                  q_neg  <= sgn && (a[31] ^ b[31]);
                  r_neg  <= sgn && a[31];
                  count  <= '0;
                  busy   <= 1'b1;
                  if ((func == F_DIV) || (func == F_DIVU)) begin
                    acc   <= {32'd0, abs_a};
                    opnd  <= abs_b;
                    state <= DIV;
                  end else begin
                    acc   <= {32'd0, abs_b};
                    opnd  <= abs_a;
                    state <= MUL;
                  end
                end
                F_MTHI:  hi <= a;
                F_MTLO:  lo <= a;
                default: ;
              endcase
            end
          end
          MUL: begin
            acc   <= {mul_sum, acc[31:1]};
            count <= count + 5'd1;
            if (count == 5'd31) state <= FIX;
          end
          DIV: begin
            if (opnd == 32'd0) begin
              // Divide by zero: give up after this single busy cycle.
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              acc   <= {(div_ge ? div_diff : div_shift[31:0]), acc[30:0], div_ge};
              count <= count + 5'd1;
              if (count == 5'd31) state <= FIX;
            end
          end
          FIX: begin
            if (is_div) begin
              lo <= quo_fix;
              hi <= rem_fix;
            end else begin
              lo <= prod_fix[31:0];
              hi <= prod_fix[63:32];
            end
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer
//   Scoreboarded bench for md_sequencer. Issued MULT/DIV commands push their
//   expected {hi,lo} into a queue; a monitor pops and compares on each done
//   pulse. Expected values come from plain 64-bit arithmetic.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  func;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_rd;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  md_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .func    (func),
    .a       (a),
    .b       (b),
    .hilo_rd (hilo_rd),
    .flush   (flush),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  logic        prev_done = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {hi,lo} straight from 64-bit integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    u  = 64'd0;
    case (f)
      3'd1: u = sx * sy;
      3'd2: u = {32'd0, x} * {32'd0, y};
      3'd3: begin
        q = sx / sy;
        r = sx % sy;
        u = {r[31:0], q[31:0]};
      end
      3'd4: u = {x % y, x / y};
      default: u = 64'd0;
    endcase
    return u;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (rst && done) begin
      done_cnt++;
      check("done_single_cycle", {63'd0, prev_done}, 64'd0);
      if (exp_q.size() == 0) check("done_unexpected", {63'd0, done}, 64'd0);
      else check("result_hilo", {hi, lo}, exp_q.pop_front());
    end
    prev_done = done;
  end

  // Present a command, hold it while stalled, and account for it in the model.
  task automatic do_cmd(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                        input bit completes, output int waits);
    logic [63:0] r;
    @(posedge clk); #1;
    start = 1'b1; func = f; a = av; b = bv;
    waits = 0;
    @(negedge clk);
    while (stall && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (stall) check("accept_timeout", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    if (f >= 3'd1 && f <= 3'd4 && !(f >= 3'd3 && bv == 32'd0)) begin
      r = ref_md(f, av, bv);
      if (completes) begin
        exp_q.push_back(r);
        m_hi = r[63:32];
        m_lo = r[31:0];
      end
    end
    if (f == 3'd5) m_hi = av;
    if (f == 3'd6) m_lo = av;
    if (f == 3'd5 || f == 3'd6) begin
      @(negedge clk);
      check("mt_hi", {32'd0, hi}, {32'd0, m_hi});
      check("mt_lo", {32'd0, lo}, {32'd0, m_lo});
      check("mt_busy", {63'd0, busy}, 64'd0);
    end
  endtask

  // Full MULT/DIV with busy length, single done and literal result checks.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
    int n;
    int d0;
    int w;
    d0 = done_cnt;
    do_cmd(f, av, bv, 1'b1, w);
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    check({name, "_busy_cycles"}, 64'(n), 64'd33);
    check({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_hi"}, {32'd0, hi}, {32'd0, eh});
    check({name, "_lo"}, {32'd0, lo}, {32'd0, el});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return $urandom_range(0, 20);
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    int          w;
    int          d0;
    logic [63:0] r1;

    rst = 1'b0; start = 1'b1; func = 3'd1; a = 32'd5; b = 32'd6;
    hilo_rd = 1'b1; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_stall", {63'd0, stall}, 64'd0);
    start = 1'b0; hilo_rd = 1'b0; func = 3'd0;
    @(posedge clk); #1;
    rst = 1'b1;

    run_op("mult_neg3x7", 3'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("divu_100_7", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_neg7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // MTLO then divide by zero: one busy cycle, no done, HI/LO unchanged.
    do_cmd(3'd6, 32'h1234, 32'd0, 1'b1, w);
    d0 = done_cnt;
    do_cmd(3'd4, 32'd5, 32'd0, 1'b1, w);
    @(negedge clk);
    check("divz_busy_first", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("divz_busy_second", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    check("divz_no_done", 64'(done_cnt - d0), 64'd0);
    check("divz_lo", {32'd0, lo}, 64'h1234);
    check("divz_hi", {32'd0, hi}, {32'd0, m_hi});

    // Dependent HI/LO read during a MULT: stalled until the result lands.
    do_cmd(3'd1, 32'h0001_2345, 32'hFFFF_0F0F, 1'b1, w);
    for (int k = 0; k <= 34; k++) begin
      if (k == 5) hilo_rd = 1'b1;
      @(negedge clk);
      if (k >= 5) check($sformatf("hilo_stall_k%0d", k), {63'd0, stall}, (k <= 32) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
    end
    hilo_rd = 1'b0;

    // Flush at cycle 10 of a MULT: back to IDLE, HI/LO keep the old result.
    d0 = done_cnt;
    do_cmd(3'd1, 32'h1111, 32'h2222, 1'b0, w);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; hilo_rd = 1'b1;
    @(negedge clk);
    check("flush_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; hilo_rd = 1'b0;
    @(negedge clk);
    check("flush_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    check("flush_no_done", 64'(done_cnt - d0), 64'd0);
    check("flush_hi", {32'd0, hi}, {32'd0, m_hi});
    check("flush_lo", {32'd0, lo}, {32'd0, m_lo});

    // Start together with flush in IDLE is ignored.
    @(posedge clk); #1;
    start = 1'b1; func = 3'd5; a = ~m_hi; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_ignored", {32'd0, hi}, {32'd0, m_hi});

    // Back-to-back: second command held until the first result is written.
    r1 = ref_md(3'd2, 32'hDEAD_BEEF, 32'h0000_1001);
    do_cmd(3'd2, 32'hDEAD_BEEF, 32'h0000_1001, 1'b1, w);
    d0 = done_cnt;
    do_cmd(3'd4, 32'hCAFE_0000, 32'd77, 1'b1, w);
    check("b2b_stall_cycles", 64'(w), 64'd32);
    check("b2b_first_done", 64'(done_cnt - d0), 64'd1);
    check("b2b_hilo_stable", {hi, lo}, r1);

    // Randomized command stream with random gaps (some overlap in-flight ops).
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] av, bv;
      f  = 3'($urandom_range(0, 7));
      av = pick();
      bv = pick();
      do_cmd(f, av, bv, 1'b1, w);
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end

    // Reset in the middle of a DIV clears everything at once.
    do_cmd(3'd3, 32'h1234_5678, 32'd3, 1'b0, w);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    run_op("mult_6x7", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42);

    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
